mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the instruction-fetch stage and the data-memory (MEM) stage of the 5-stage pipeline.
- Sequences each access: grant, issue, wait for latency, capture, acknowledge.
- Generates stall controls for the PC and the pipeline buffers while an access is outstanding.
- Sits between the IF/MEM stages and the unified memory model. It replaces the separate instruction and data memories when the core moves to a unified memory.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/arb_rr2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and latency bounds for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        DONE  = ST_DONE
    } arb_state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 15;
    localparam int unsigned CNT_W       = 4;

    // Counter preload (latency - 1), clamped into the legal latency range.
    function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
        int unsigned l;
        l = lat;
        if (l < MEM_LAT_MIN) l = MEM_LAT_MIN;
        if (l > MEM_LAT_MAX) l = MEM_LAT_MAX;
        return CNT_W'(l - 1);
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker between fetch and data requests.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    // On contention the requester not served last wins.
    always_comb begin
        gnt_valid = if_req | d_req;
        gnt_id    = GNT_IF;
        if (if_req && d_req) begin
            gnt_id = (last_grant == GNT_IF) ? GNT_D : GNT_IF;
        end else if (d_req) begin
            gnt_id = GNT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage,
// sequencing grant/issue/wait/capture/ack and producing pipeline stalls.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_pipe
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);
    localparam bit               LAT_GT1  = (MEM_LAT > 1);

    arb_state_t        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              gnt_id_q, gnt_id_d;
    logic              last_grant, last_grant_d;
    logic              acc_we, acc_we_d;
    logic              mem_en_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              if_ack_d, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              arb_valid, arb_id;

    arb_rr2 u_arb (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .gnt_valid  (arb_valid),
        .gnt_id     (arb_id)
    );

    // Next-state, counter and register-file update.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        gnt_id_d     = gnt_id_q;
        last_grant_d = last_grant;
        acc_we_d     = acc_we;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_d  = ISSUE;
                    gnt_id_d = arb_id;
                    mem_en_d = 1'b1;
                    if (arb_id == GNT_D) begin
                        acc_we_d    = d_we;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        acc_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_d = LAT_LOAD;
                if (LAT_GT1) begin
                    state_d  = WAIT;
                    mem_we_d = acc_we;
                end else begin
                    state_d  = DONE;
                    if_ack_d = (gnt_id_q == GNT_IF);
                    d_ack_d  = (gnt_id_q == GNT_D);
                end
            end
            WAIT: begin
                if (cnt <= CNT_W'(1)) begin
                    cnt_d    = '0;
                    state_d  = DONE;
                    if_ack_d = (gnt_id_q == GNT_IF);
                    d_ack_d  = (gnt_id_q == GNT_D);
                end else begin
                    cnt_d    = cnt - CNT_W'(1);
                    mem_we_d = acc_we;
                end
            end
            DONE: begin
                // Read data is live this cycle; stores leave d_rdata alone.
                if (gnt_id_q == GNT_IF) begin
                    if_rdata_d = mem_rdata;
                end else if (!acc_we) begin
                    d_rdata_d = mem_rdata;
                end
                last_grant_d = gnt_id_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            gnt_id_q   <= GNT_IF;
            last_grant <= GNT_IF;
            acc_we     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            gnt_id_q   <= gnt_id_d;
            last_grant <= last_grant_d;
            acc_we     <= acc_we_d;
            mem_en     <= mem_en_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            if_ack     <= if_ack_d;
            d_ack      <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Memory data is only valid in DONE, so the ack cycle forwards it directly.
    assign if_rdata = if_ack ? mem_rdata : if_rdata_q;
    assign d_rdata  = (d_ack && !acc_we) ? mem_rdata : d_rdata_q;

    assign stall_if   = if_req & ~if_ack;
    assign stall_pipe = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard and corner sequences.
module tb_mem_port_arbiter;

    localparam int unsigned LAT  = 2;
    localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, d_ack, mem_en, mem_we, stall_if, stall_pipe;

    logic        l1_if_req, l1_d_req, l1_d_we;
    logic [31:0] l1_if_addr, l1_d_addr, l1_d_wdata;
    logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
    logic        l1_if_ack, l1_d_ack, l1_mem_en, l1_mem_we, l1_stall_if, l1_stall_pipe;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_pipe(stall_pipe)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_ack(l1_if_ack),
        .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_rdata(l1_d_rdata), .d_ack(l1_d_ack),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_rdata(l1_mem_rdata), .stall_if(l1_stall_if), .stall_pipe(l1_stall_pipe)
    );

    // Memory model: word-addressed array, data valid only LAT cycles after mem_en.
    logic [31:0] mem [256];
    logic [1:0]  pv;
    logic [31:0] pa0, pa1;
    logic        l1_pv;
    logic [31:0] l1_pa;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[1]  <= 32'h2008_0005;
            mem[4]  <= 32'h1111_1111;
            mem[16] <= 32'hCAFE_F00D;
            pv      <= '0;
            l1_pv   <= 1'b0;
        end else begin
            pv    <= {pv[0], mem_en};
            l1_pv <= l1_mem_en;
            if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        end
        pa0   <= mem_addr;
        pa1   <= pa0;
        l1_pa <= l1_mem_addr;
    end

    assign mem_rdata    = pv[1] ? mem[pa1[9:2]] : JUNK;
    assign l1_mem_rdata = l1_pv ? mem[l1_pa[9:2]] : JUNK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected read data pushed at request, popped on ack.
    logic [31:0] if_exp_q[$];
    logic [31:0] d_exp_q[$];
    logic        ack_log[$];

    always @(negedge clk) begin
        if (if_ack) begin
            if (if_exp_q.size() == 0) chk("if_ack_unexpected", 32'(if_ack), 32'd0);
            else chk("if_rdata", if_rdata, if_exp_q.pop_front());
            ack_log.push_back(1'b0);
        end
        if (d_ack) begin
            if (d_exp_q.size() == 0) chk("d_ack_unexpected", 32'(d_ack), 32'd0);
            else chk("d_rdata", d_rdata, d_exp_q.pop_front());
            ack_log.push_back(1'b1);
        end
    end

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One isolated access with cycle-exact checks relative to the request cycle.
    task automatic run_vec(input vec_t v);
        int en_k  = -1;
        int ack_k = -1;
        @(posedge clk); #1;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
            d_exp_q.push_back(v.exp);
        end else begin
            if_req = 1'b1; if_addr = v.addr;
            if_exp_q.push_back(v.exp);
        end
        for (int k = 0; k < 40 && ack_k < 0; k++) begin
            @(negedge clk);
            if (mem_en) begin
                if (en_k < 0) en_k = k;
                chk("mem_addr", mem_addr, v.addr);
                if (v.we) chk("mem_wdata", mem_wdata, v.wdata);
            end
            chk("mem_we_window", 32'(mem_we), 32'(v.we && k >= 1 && k <= int'(LAT)));
            if (v.is_d ? d_ack : if_ack) ack_k = k;
            chk("stall", 32'(v.is_d ? stall_pipe : stall_if), 32'(ack_k < 0));
            chk("other_ack", 32'(v.is_d ? if_ack : d_ack), 32'd0);
        end
        chk("mem_en_cycle", 32'(en_k), 32'd1);
        chk("ack_cycle", 32'(ack_k), 32'(1 + LAT));
        @(posedge clk); #1;
        if (v.is_d) d_req = 1'b0; else if_req = 1'b0;
    endtask

    // Requester holding req high across n back-to-back loads/fetches.
    task automatic drive_port(input bit is_d, input int n, input logic [31:0] addr,
                              input logic [31:0] exp);
        for (int i = 0; i < n; i++) begin
            bit got = 1'b0;
            @(posedge clk); #1;
            if (is_d) begin
                d_req = 1'b1; d_we = 1'b0; d_addr = addr;
                d_exp_q.push_back(exp);
            end else begin
                if_req = 1'b1; if_addr = addr;
                if_exp_q.push_back(exp);
            end
            for (int w = 0; w < 40 && !got; w++) begin
                @(negedge clk);
                if (is_d ? d_ack : if_ack) got = 1'b1;
            end
            chk("port_ack_seen", 32'(got), 32'd1);
        end
        @(posedge clk); #1;
        if (is_d) d_req = 1'b0; else if_req = 1'b0;
    endtask

    logic exp_order[6];

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        l1_if_req = 1'b0; l1_if_addr = '0;
        l1_d_req = 1'b0; l1_d_we = 1'b0; l1_d_addr = '0; l1_d_wdata = '0;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         32'h2008_0005};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h1111_1111};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'h1111_1111};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678};
        vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000};
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_stall_if", 32'(stall_if), 32'd0);
        chk("rst_stall_pipe", 32'(stall_pipe), 32'd0);
        chk("rst_l1_mem_en", 32'(l1_mem_en), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Simultaneous requests after reset: data wins, fetch follows.
        do_reset();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        if_exp_q.push_back(32'h2008_0005);
        d_exp_q.push_back(32'h1111_1111);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("cont_mem_en", 32'(mem_en), 32'(k == 1 || k == 5));
            chk("cont_d_ack", 32'(d_ack), 32'(k == 3));
            chk("cont_if_ack", 32'(if_ack), 32'(k == 7));
            chk("cont_stall_if", 32'(stall_if), 32'(k < 7));
            chk("cont_stall_pipe", 32'(stall_pipe), 32'(k < 3));
            if (k == 3) begin @(posedge clk); #1 d_req = 1'b0; end
            if (k == 7) begin @(posedge clk); #1 if_req = 1'b0; end
        end

        // Both requesters held for six accesses: strict alternation.
        do_reset();
        ack_log.delete();
        fork
            drive_port(1'b0, 3, 32'h4, 32'h2008_0005);
            drive_port(1'b1, 3, 32'h10, 32'h1111_1111);
        join
        chk("rr_ack_count", 32'(ack_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < ack_log.size(); i++)
            chk("rr_order", 32'(ack_log[i]), 32'(exp_order[i]));

        // Reset during WAIT of a load, with a request present while reset is high.
        repeat (2) @(posedge clk);
        #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        @(negedge clk);
        @(negedge clk);
        chk("abort_issue_en", 32'(mem_en), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk("abort_wait_ack", 32'(d_ack), 32'd0);
        @(posedge clk); #1;
        d_req = 1'b1;
        @(negedge clk);
        chk("abort_d_ack", 32'(d_ack), 32'd0);
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_d_rdata", d_rdata, 32'd0);
        chk("abort_if_rdata", if_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        d_exp_q.push_back(32'h1111_1111);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rerun_mem_en", 32'(mem_en), 32'(k == 1));
            chk("rerun_d_ack", 32'(d_ack), 32'(k == 3));
            if (k == 3) begin @(posedge clk); #1 d_req = 1'b0; end
        end

        // Single-cycle latency build.
        @(posedge clk); #1;
        l1_if_req = 1'b1; l1_if_addr = 32'h4;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("l1_mem_en", 32'(l1_mem_en), 32'(k == 1));
            chk("l1_if_ack", 32'(l1_if_ack), 32'(k == 2));
            chk("l1_stall_if", 32'(l1_stall_if), 32'(k < 2));
            chk("l1_mem_we", 32'(l1_mem_we), 32'd0);
            if (k == 2) begin
                chk("l1_if_rdata", l1_if_rdata, 32'h2008_0005);
                @(posedge clk); #1 l1_if_req = 1'b0;
            end
        end
        chk("l1_held_rdata", l1_if_rdata, 32'h2008_0005);
        chk("l1_d_ack", 32'(l1_d_ack), 32'd0);
        chk("l1_d_rdata", l1_d_rdata, 32'd0);
        chk("l1_mem_wdata", l1_mem_wdata, 32'd0);
        chk("l1_stall_pipe", 32'(l1_stall_pipe), 32'd0);

        repeat (3) @(negedge clk);
        chk("if_sb_empty", 32'(if_exp_q.size()), 32'd0);
        chk("d_sb_empty", 32'(d_exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
